// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// RAW hazard unit for the pipelined RV32I core. It keeps a shift register of
// the destination of every in-flight instruction across NUM_STAGES post-decode
// stages. Stage 1 is the EX output and stage NUM_STAGES is the last stage
// before the regfile write. For each decode source it picks a forwarding stage
// or raises a stall.
//
// Build option:
//   HAZ_FORWARDING_EN  defined   : forward from the youngest matching stage.
//                                  A load that has not yet reached
//                                  LOAD_READY_STAGE stalls the consumer.
//                      undefined : no forwarding. fwd_sel_* are tied to 0, and
//                                  any match stalls until the producer
//                                  retires.
//
// Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   id_valid      decode slot holds a real instruction
//   id_rs1/2      source indices, id_rs1/2_used marks real reads
//   id_rd         destination index, id_rd_we marks a real write
//   id_is_load    decode instruction is a load
//   flush         kill the decode-slot instruction this cycle
//   stall         hold PC and IF/ID, insert bubble (combinational)
//   fwd_sel_rs1/2 0 = regfile, k = forward from stage k (combinational)
//   stall_count   saturating count of stall cycles (registered)
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_STAGES       = 3,
  parameter int REG_ADDR_W       = 5,
  parameter int LOAD_READY_STAGE = 2,
  parameter int CNT_W            = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid,
  input  logic [REG_ADDR_W-1:0]           id_rs1,
  input  logic [REG_ADDR_W-1:0]           id_rs2,
  input  logic                            id_rs1_used,
  input  logic                            id_rs2_used,
  input  logic [REG_ADDR_W-1:0]           id_rd,
  input  logic                            id_rd_we,
  input  logic                            id_is_load,
  input  logic                            flush,
  output logic                            stall,
  output logic [$clog2(NUM_STAGES+1)-1:0] fwd_sel_rs1,
  output logic [$clog2(NUM_STAGES+1)-1:0] fwd_sel_rs2,
  output logic [CNT_W-1:0]                stall_count
);

  localparam int SEL_W = $clog2(NUM_STAGES+1);

  // Per-stage scoreboard entries. Only the valid bits are reset. The data
  // fields are always qualified by the valid bits, so they need no reset.
  logic [NUM_STAGES:1]   vld_p;
  logic [REG_ADDR_W-1:0] rd_p [1:NUM_STAGES];
  logic                  we_p [1:NUM_STAGES];
`ifdef HAZ_FORWARDING_EN
  logic                  ld_p [1:NUM_STAGES];
`endif

  logic             hit_rs1, hit_rs2;
  logic             blk_rs1, blk_rs2;
  logic [SEL_W-1:0] sel_rs1, sel_rs2;
  logic             haz_rs1, haz_rs2;
  logic             accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Returns {hit, blocking, stage}. The search runs from oldest to youngest,
  // so the youngest matching stage wins. "blocking" means the winning
  // producer cannot supply its value to this consumer yet.
  function automatic logic [SEL_W+1:0] find_src(input logic [REG_ADDR_W-1:0] r,
                                                input logic                  used);
    logic [SEL_W+1:0] res;
    res = '0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (used && (r != '0) && vld_p[k] && we_p[k] && (rd_p[k] == r)) begin
`ifdef HAZ_FORWARDING_EN
        res = {1'b1, ld_p[k] && (k < LOAD_READY_STAGE), SEL_W'(k)};
`else
        res = {1'b1, 1'b1, SEL_W'(k)};
`endif
      end
    end
    return res;
  endfunction

  // Decode-stage lookup
  always_comb begin
    {hit_rs1, blk_rs1, sel_rs1} = find_src(id_rs1, id_rs1_used);
    {hit_rs2, blk_rs2, sel_rs2} = find_src(id_rs2, id_rs2_used);
    haz_rs1 = hit_rs1 & blk_rs1;
    haz_rs2 = hit_rs2 & blk_rs2;
    // flush overrides stall. A killed instruction never waits on anything.
    stall   = id_valid & ~flush & (haz_rs1 | haz_rs2);
    accept  = id_valid & ~flush & ~(haz_rs1 | haz_rs2);
`ifdef HAZ_FORWARDING_EN
    fwd_sel_rs1 = haz_rs1 ? '0 : sel_rs1;
    fwd_sel_rs2 = haz_rs2 ? '0 : sel_rs2;
`else
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
`endif
  end

`ifndef HAZ_FORWARDING_EN
  logic unused_noforward;
  assign unused_noforward = ^{id_is_load, sel_rs1, sel_rs2, 1'(LOAD_READY_STAGE)};
`endif

  // Stage 1..NUM_STAGES control. The older stages always advance. A stall
  // only turns the stage 1 entry into a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p       <= '0;
      stall_count <= '0;
    end else begin
      vld_p[1] <= accept;
      for (int k = 2; k <= NUM_STAGES; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
      if (stall) begin
        stall_count <= sat_inc(stall_count);
      end
    end
  end

  // Stage 1..NUM_STAGES data
  always_ff @(posedge clk) begin
    rd_p[1] <= id_rd;
    we_p[1] <= id_rd_we;
`ifdef HAZ_FORWARDING_EN
    ld_p[1] <= id_is_load;
`endif
    for (int k = 2; k <= NUM_STAGES; k++) begin
      rd_p[k] <= rd_p[k-1];
      we_p[k] <= we_p[k-1];
`ifdef HAZ_FORWARDING_EN
      ld_p[k] <= ld_p[k-1];
`endif
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int NS  = 3;
  localparam int AW  = 5;
  localparam int LRS = 2;
  localparam int CW  = 4;
  localparam int SW  = $clog2(NS+1);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_LW  = 2'd2;
  localparam logic [31:0] LOAD_VAL = 32'd77;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, flush;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          stall;
  logic [SW-1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic [CW-1:0] stall_count;

  hazard_scoreboard #(
    .NUM_STAGES(NS), .REG_ADDR_W(AW), .LOAD_READY_STAGE(LRS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .flush(flush), .stall(stall),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vld;
    logic [1:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       we;
    logic       fl;
  } instr_t;

  typedef struct {
    int            scen;
    logic          rstb;
    instr_t        in;
    logic          est;
    logic [SW-1:0] ef1;
    logic [SW-1:0] ef2;
  } vec_t;

  // One record per accepted instruction still in flight. The record keeps the
  // cycle it entered stage 1, so its current stage is derived from elapsed time.
  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    int          enter;
    logic [31:0] val;
  } fly_t;

  fly_t          fly[$];
  vec_t          vecs[$];
  int            cyc;
  int            n_chk;
  int            n_fail;
  logic [31:0]   rf   [32];
  logic [31:0]   gold [32];
  logic [CW-1:0] m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic instr_t mki(input logic [1:0] op, input int rd, input int rs1,
                                 input int rs2, input bit fl);
    instr_t i;
    i.vld = 1'b1; i.op = op; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    i.u1 = 1'b1; i.u2 = (op != OP_LW); i.we = 1'b1; i.fl = fl;
    return i;
  endfunction

  function automatic instr_t bub();
    instr_t i;
    i = '0;
    return i;
  endfunction

  function automatic void addv(input int scen, input bit rstb, input instr_t in,
                               input bit est, input int f1, input int f2);
    vec_t v;
    v.scen = scen; v.rstb = rstb; v.in = in; v.est = est;
    v.ef1 = SW'(f1); v.ef2 = SW'(f2);
    vecs.push_back(v);
  endfunction

  function automatic logic [31:0] alu(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      OP_SUB:  return a - b;
      OP_LW:   return LOAD_VAL;
      default: return a + b;
    endcase
  endfunction

  // Operand as the datapath would see it, steered by the DUT's select.
  function automatic logic [31:0] opnd(input logic [4:0] r, input logic [SW-1:0] f);
    if (f == '0) return rf[r];
    foreach (fly[i]) if (cyc - fly[i].enter + 1 == int'(f)) return fly[i].val;
    return 32'hDEADBEEF;
  endfunction

  // Reference rule: the youngest in-flight writer of r decides.
  task automatic src_eval(input logic [4:0] r, input logic used,
                          output logic haz, output logic [SW-1:0] sel);
    haz = 1'b0;
    sel = '0;
    if (!used || r == 5'd0) return;
    for (int i = fly.size() - 1; i >= 0; i--) begin
      if (fly[i].we && fly[i].rd == r) begin
        int stg;
        stg = cyc - fly[i].enter + 1;
`ifdef HAZ_FORWARDING_EN
        if (fly[i].ld && stg < LRS) haz = 1'b1;
        else sel = SW'(stg);
`else
        haz = 1'b1;
`endif
        return;
      end
    end
  endtask

  task automatic drive(input instr_t in);
    id_valid    = in.vld;
    id_rs1      = in.rs1;
    id_rs2      = in.rs2;
    id_rs1_used = in.u1;
    id_rs2_used = in.u2;
    id_rd       = in.rd;
    id_rd_we    = in.we;
    id_is_load  = (in.op == OP_LW);
    flush       = in.fl;
  endtask

  task automatic tick(input instr_t in, input bit tab, input logic est,
                      input logic [SW-1:0] ef1, input logic [SW-1:0] ef2, output bit acc);
    logic          mst, h1, h2;
    logic [SW-1:0] mf1, mf2;
    logic [31:0]   a, b, ga, gb, val;
    fly_t          f;
    drive(in);
    @(negedge clk);
    src_eval(in.rs1, in.u1, h1, mf1);
    src_eval(in.rs2, in.u2, h2, mf2);
    mst = in.vld & ~in.fl & (h1 | h2);
    chk("stall", 32'(stall), 32'(mst));
    chk("fwd_sel_rs1", 32'(fwd_sel_rs1), 32'(mf1));
    chk("fwd_sel_rs2", 32'(fwd_sel_rs2), 32'(mf2));
    chk("stall_count", 32'(stall_count), 32'(m_cnt));
    if (tab) begin
      chk("vec_stall", 32'(stall), 32'(est));
      chk("vec_fwd_rs1", 32'(fwd_sel_rs1), 32'(ef1));
      chk("vec_fwd_rs2", 32'(fwd_sel_rs2), 32'(ef2));
    end
    acc = in.vld & ~in.fl & ~mst;
    val = '0;
    if (acc) begin
      a   = in.u1 ? opnd(in.rs1, fwd_sel_rs1) : 32'd0;
      b   = in.u2 ? opnd(in.rs2, fwd_sel_rs2) : 32'd0;
      ga  = in.u1 ? gold[in.rs1] : 32'd0;
      gb  = in.u2 ? gold[in.rs2] : 32'd0;
      val = alu(in.op, a, b);
      if (in.we && in.rd != 5'd0) gold[in.rd] = alu(in.op, ga, gb);
    end
    if (mst && m_cnt != CMAX) m_cnt = m_cnt + CW'(1);
    @(posedge clk);
    cyc++;
    while (fly.size() > 0 && cyc - fly[0].enter + 1 > NS) begin
      f = fly.pop_front();
      if (f.we && f.rd != 5'd0) rf[f.rd] = f.val;
    end
    if (acc) begin
      f.rd = in.rd; f.we = in.we; f.ld = (in.op == OP_LW); f.enter = cyc; f.val = val;
      fly.push_back(f);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(bub());
    @(posedge clk);
    #1;
    rst = 1'b0;
    fly.delete();
    m_cnt = '0;
  endtask

  task automatic drain();
    bit acc;
    repeat (NS) tick(bub(), 1'b0, 1'b0, '0, '0, acc);
  endtask

  task automatic scen_end(input int s);
    drain();
    case (s)
      1: begin
        chk("s1_x1", rf[1], 32'd1);
        chk("s1_x4", rf[4], 32'd4);
        chk("s1_x5", rf[5], 32'd3);
        chk("s1_x10", rf[10], 32'd2);
`ifdef HAZ_FORWARDING_EN
        chk("s1_stall_count", 32'(stall_count), 32'd0);
`else
        chk("s1_stall_count", 32'(stall_count), 32'd3);
`endif
      end
      2: begin
        chk("s2_x1", rf[1], 32'd77);
        chk("s2_x2", rf[2], 32'd154);
`ifdef HAZ_FORWARDING_EN
        chk("s2_stall_count", 32'(stall_count), 32'd1);
`else
        chk("s2_stall_count", 32'(stall_count), 32'd3);
`endif
      end
      3: begin
        chk("s3_x6", rf[6], 32'd0);
        chk("s3_stall_count", 32'(stall_count), 32'd0);
      end
      default: begin
        chk("s5_x11", rf[11], 32'd0);
        chk("s5_x8", rf[8], 32'd154);
        chk("s5_x9", rf[9], 32'd0);
`ifdef HAZ_FORWARDING_EN
        chk("s5_stall_count", 32'(stall_count), 32'd0);
`else
        chk("s5_stall_count", 32'(stall_count), 32'd2);
`endif
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit     acc;
    int     nst;
    int     bad;
    instr_t r;

    n_chk = 0; n_fail = 0; cyc = 0; m_cnt = '0;
    for (int i = 0; i < 32; i++) begin rf[i] = '0; gold[i] = '0; end
    rf[2] = 32'd2; rf[3] = 32'd3; gold[2] = 32'd2; gold[3] = 32'd3;

    // Scenario 1: forwarding chain sub x1 / add x4 / add x5 / add x10
    addv(1, 1, mki(OP_SUB, 1, 3, 2, 0), 0, 0, 0);
`ifdef HAZ_FORWARDING_EN
    addv(1, 0, mki(OP_ADD, 4, 1, 3, 0), 0, 1, 0);
`else
    addv(1, 0, mki(OP_ADD, 4, 1, 3, 0), 1, 0, 0);
    addv(1, 0, mki(OP_ADD, 4, 1, 3, 0), 1, 0, 0);
    addv(1, 0, mki(OP_ADD, 4, 1, 3, 0), 1, 0, 0);
    addv(1, 0, mki(OP_ADD, 4, 1, 3, 0), 0, 0, 0);
`endif
`ifdef HAZ_FORWARDING_EN
    addv(1, 0, mki(OP_ADD, 5, 2, 1, 0), 0, 0, 2);
    addv(1, 0, mki(OP_ADD, 10, 1, 1, 0), 0, 3, 3);
`else
    addv(1, 0, mki(OP_ADD, 5, 2, 1, 0), 0, 0, 0);
    addv(1, 0, mki(OP_ADD, 10, 1, 1, 0), 0, 0, 0);
`endif
    // Scenario 2: load-use
    addv(2, 1, mki(OP_LW, 1, 0, 0, 0), 0, 0, 0);
    addv(2, 0, mki(OP_ADD, 2, 1, 1, 0), 1, 0, 0);
`ifdef HAZ_FORWARDING_EN
    addv(2, 0, mki(OP_ADD, 2, 1, 1, 0), 0, 2, 2);
`else
    addv(2, 0, mki(OP_ADD, 2, 1, 1, 0), 1, 0, 0);
    addv(2, 0, mki(OP_ADD, 2, 1, 1, 0), 1, 0, 0);
    addv(2, 0, mki(OP_ADD, 2, 1, 1, 0), 0, 0, 0);
`endif
    // Scenario 3: x0 destination never matches
    addv(3, 1, mki(OP_ADD, 0, 3, 3, 0), 0, 0, 0);
    addv(3, 0, mki(OP_ADD, 6, 0, 0, 0), 0, 0, 0);
    // Scenario 5: flush during the load-use stall cycle
    addv(5, 1, mki(OP_LW, 1, 0, 0, 0), 0, 0, 0);
    addv(5, 0, mki(OP_ADD, 11, 1, 1, 1), 0, 0, 0);
`ifdef HAZ_FORWARDING_EN
    addv(5, 0, mki(OP_ADD, 8, 1, 1, 0), 0, 2, 2);
`else
    addv(5, 0, mki(OP_ADD, 8, 1, 1, 0), 1, 0, 0);
    addv(5, 0, mki(OP_ADD, 8, 1, 1, 0), 1, 0, 0);
    addv(5, 0, mki(OP_ADD, 8, 1, 1, 0), 0, 0, 0);
`endif
    addv(5, 0, mki(OP_ADD, 9, 11, 11, 0), 0, 0, 0);

    // Power-on reset state
    rst = 1'b1;
    drive(bub());
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_fwd_rs1", 32'(fwd_sel_rs1), 32'd0);
    chk("reset_fwd_rs2", 32'(fwd_sel_rs2), 32'd0);
    chk("reset_stall_count", 32'(stall_count), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rstb) do_reset();
      tick(vecs[i].in, 1'b1, vecs[i].est, vecs[i].ef1, vecs[i].ef2, acc);
      if (i == vecs.size() - 1 || vecs[i+1].scen != vecs[i].scen) scen_end(vecs[i].scen);
    end

    // Saturation: at least 20 stall cycles into a 4-bit counter
    do_reset();
    nst = 0;
    for (int p = 0; p < 20 && nst < 20; p++) begin
      tick(mki(OP_LW, 1, 0, 0, 0), 1'b0, 1'b0, '0, '0, acc);
      for (int t = 0; t < 6; t++) begin
        tick(mki(OP_ADD, 2, 1, 1, 0), 1'b0, 1'b0, '0, '0, acc);
        if (acc) break;
        nst++;
      end
    end
    chk("stall_count_saturated", 32'(stall_count), 32'd15);

    // Asynchronous reset in the middle of a load-use stall
    tick(mki(OP_LW, 1, 0, 0, 0), 1'b0, 1'b0, '0, '0, acc);
    drive(mki(OP_ADD, 2, 1, 1, 0));
    #2;
    chk("pre_reset_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("midreset_stall", 32'(stall), 32'd0);
    chk("midreset_fwd_rs1", 32'(fwd_sel_rs1), 32'd0);
    chk("midreset_fwd_rs2", 32'(fwd_sel_rs2), 32'd0);
    chk("midreset_stall_count", 32'(stall_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fly.delete();
    m_cnt = '0;
    tick(mki(OP_ADD, 2, 1, 1, 0), 1'b1, 1'b0, '0, '0, acc);
    drain();

    // Randomized traffic on a small register set against the reference model
    for (int n = 0; n < 600; n++) begin
      r.vld = ($urandom_range(0, 7) != 0);
      r.op  = 2'($urandom_range(0, 2));
      r.rd  = 5'($urandom_range(0, 3));
      r.rs1 = 5'($urandom_range(0, 3));
      r.rs2 = 5'($urandom_range(0, 3));
      r.u1  = ($urandom_range(0, 5) != 0);
      r.u2  = ($urandom_range(0, 5) != 0);
      r.we  = ($urandom_range(0, 4) != 0);
      r.fl  = ($urandom_range(0, 9) == 0);
      tick(r, 1'b0, 1'b0, '0, '0, acc);
    end
    drain();
    bad = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== gold[i]) bad++;
    chk("random_regfile_vs_inorder", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
